spmmio_arbiter: RTL and testbench
=================================

SPMMIO_ARBITER -- requirements
Module: spmmio_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles a granted strobe waits for s_ack_i before a bus error; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_cyc_i, m1_cyc_i  input  1  master N bus cycle in progress.
REQ-005 m0_stb_i, m1_stb_i  input  1  master N strobe.
REQ-006 m0_we_i, m1_we_i  input  1  master N write enable.
REQ-007 m0_adr_i, m1_adr_i  input  [0:23]  master N address; bit 21 is the last significant bit.
REQ-008 m0_sel_i, m1_sel_i  input  [0:3]  master N byte selects.
REQ-009 m0_dat_i, m1_dat_i  input  [0:31]  master N write data.
REQ-010 m0_ack_o, m1_ack_o  output  1  master N acknowledge.
REQ-011 m0_err_o, m1_err_o  output  1  master N timeout error.
REQ-012 m0_dat_o, m1_dat_o  output  [0:31]  master N read data.
REQ-013 s_cyc_o, s_stb_o, s_we_o  output  1 each  cycle, strobe and write enable to the spmmio slave.
REQ-014 s_adr_o  output  [0:23]  address to the slave.
REQ-015 s_sel_o  output  [0:3]  byte selects to the slave.
REQ-016 s_dat_o  output  [0:31]  write data to the slave.
REQ-017 s_ack_i  input  1  slave acknowledge; may stall for many cycles.
REQ-018 s_dat_i  input  [0:31]  slave read data.

Function
REQ-019 The FSM SHALL have three states: IDLE, GNT0 and GNT1.
REQ-020 In IDLE, a request is mN_cyc_i&mN_stb_i; a single requester SHALL be granted on the next edge; with two requesters, the master not served last SHALL be granted.
REQ-021 Grant latency SHALL be exactly one cycle: s_cyc_o rises on the cycle after the request is first seen in IDLE.
REQ-022 In GNTn, the s_* outputs SHALL combinationally mirror master n's inputs; with no grant, s_* SHALL be all zero.
REQ-023 s_ack_i and s_dat_i SHALL reach only the granted master; the other master SHALL see ack=0, err=0 and dat=0.
REQ-024 The grant SHALL be held while the granted mN_cyc_i=1, covering multi-strobe cycles; when it drops, the FSM SHALL return to IDLE and record n as last served.
REQ-025 Rearbitration SHALL therefore cost one IDLE cycle; there SHALL be no back-to-back handover.
REQ-026 A request from the non-granted master SHALL be held pending without loss and served next.
REQ-027 Simultaneous first requests after reset SHALL grant m0.

Reset
REQ-028 Reset SHALL force IDLE, set last-served to m1, clear the timeout counter and drive every output to 0.
REQ-029 Reset mid-transfer SHALL drop s_cyc_o/s_stb_o immediately and SHALL emit no ack or err.

Configuration
REQ-030 With SPMMIO_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear whenever s_stb_o=0 or s_ack_i=1, and otherwise increment.
REQ-031 When the counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse mN_err_o for 1 cycle, gate s_stb_o low for that cycle and clear the counter; grant release still follows REQ-024.
REQ-032 Without SPMMIO_ARB_TIMEOUT_EN, no counter SHALL exist, mN_err_o SHALL be tied to 0, and a stalled slave SHALL hold the grant indefinitely.

Structure
REQ-033 The FSM state enum and the DEFAULT_TIMEOUT_CYCLES constant SHALL live in the shared package spmmio_pkg.
REQ-034 The timeout counter SHALL be a separate sub-module, spmmio_arb_watchdog, instantiated only under SPMMIO_ARB_TIMEOUT_EN.

Verification
REQ-035 m0 reads 0x000004 alone, slave acks 2 cycles later with 0x12345678 -> s_cyc_o rises at cycle+1, m0_dat_o=0x12345678, m1_ack_o=0 throughout.
REQ-036 m0 and m1 request in the same cycle after reset -> m0 is granted, m1 follows after a single IDLE cycle; both request again -> m1 is granted, then m0.
REQ-037 m1 holds cyc across 3 strobes to 0x010000 while m0 requests -> all 3 strobes complete on m1 before m0 is granted.
REQ-038 With the macro defined and TIMEOUT_CYCLES=8, the slave never acks -> m0_err_o pulses once, 8 cycles after s_stb_o rose; m0_ack_o stays 0.
REQ-039 Reset asserted while the m0 transfer is stalled -> all outputs are 0 at once; after release, a pending m1 request is granted first.

Source files
------------

// File: rtl/spmmio_pkg.sv
// Shared types and constants for the spmmio two-master arbiter.
package spmmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/spmmio_arb_watchdog.sv
// Stall watchdog: raises a one-cycle expire pulse after TIMEOUT_CYCLES strobe
// cycles without an acknowledge. Instantiated only under SPMMIO_ARB_TIMEOUT_EN.
module spmmio_arb_watchdog
  import spmmio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic stb_i,
  input  logic ack_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        expire_q, expire_d;
  logic        at_limit;

  always_comb begin
    at_limit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    expire_d = stb_i & ~ack_i & at_limit;
    if (!stb_i || ack_i || at_limit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/spmmio_arbiter.sv
// Two-master round-robin arbiter in front of a single spmmio slave.
// Optional slave-stall timeout enabled by defining SPMMIO_ARB_TIMEOUT_EN.
module spmmio_arbiter
  import spmmio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [0:23] m0_adr_i,
  input  logic [0:3]  m0_sel_i,
  input  logic [0:31] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [0:31] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [0:23] m1_adr_i,
  input  logic [0:3]  m1_sel_i,
  input  logic [0:31] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [0:31] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [0:23] s_adr_o,
  output logic [0:3]  s_sel_o,
  output logic [0:31] s_dat_o,
  input  logic        s_ack_i,
  input  logic [0:31] s_dat_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("spmmio_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;  // 1 = m1 was served last
  logic       req0, req1;
  logic       expire;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef SPMMIO_ARB_TIMEOUT_EN
  // Watchdog sees the gated strobe, so the expire cycle itself clears the count.
  spmmio_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .stb_i   (s_stb_o),
    .ack_i   (s_ack_i),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~expire;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = expire;
        m0_dat_o = s_dat_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~expire;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = expire;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spmmio_arbiter.sv
// Directed bench for spmmio_arbiter with a cycle-level reference model.
module tb_spmmio_arbiter;

  localparam int unsigned TO = 8;
`ifdef SPMMIO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [0:23] m0_adr_i;
  logic [0:3]  m0_sel_i;
  logic [0:31] m0_dat_i;
  logic        m0_ack_o, m0_err_o;
  logic [0:31] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [0:23] m1_adr_i;
  logic [0:3]  m1_sel_i;
  logic [0:31] m1_dat_i;
  logic        m1_ack_o, m1_err_o;
  logic [0:31] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [0:23] s_adr_o;
  logic [0:3]  s_sel_o;
  logic [0:31] s_dat_o;
  logic        s_ack_i;
  logic [0:31] s_dat_i;

  int tests = 0;
  int failures = 0;

  spmmio_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the slave, who was served last, and how many
  // consecutive cycles the visible strobe has gone unacknowledged.
  int owner  = -1;
  int last   = 1;
  int waited = 0;

  function automatic logic [130:0] expect_outs();
    logic        cyc, stb, we, err;
    logic [0:23] adr;
    logic [0:3]  sel;
    logic [0:31] dat, d0, d1;
    logic        a0, a1, e0, e1;
    {cyc, stb, we, adr, sel, dat} = '0;
    {a0, a1, e0, e1} = '0;
    d0 = '0;
    d1 = '0;
    if (reset) return '0;
    err = TO_EN && owner >= 0 && waited == int'(TO);
    if (owner == 0) begin
      {cyc, stb, we, adr, sel, dat} = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i};
      a0 = s_ack_i; e0 = err; d0 = s_dat_i;
    end else if (owner == 1) begin
      {cyc, stb, we, adr, sel, dat} = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i};
      a1 = s_ack_i; e1 = err; d1 = s_dat_i;
    end
    stb = stb & ~err;
    return {a0, a1, e0, e1, d0, d1, cyc, stb, we, adr, sel, dat};
  endfunction

  always @(posedge clk or posedge reset) begin
    logic vis, r0, r1, oc;
    if (reset) begin
      owner  = -1;
      last   = 1;
      waited = 0;
    end else begin
      vis = 1'b0;
      if (owner >= 0)
        vis = (owner == 0 ? m0_stb_i : m1_stb_i) && !(TO_EN && waited == int'(TO));
      waited = (vis && !s_ack_i) ? waited + 1 : 0;
      r0 = m0_cyc_i & m0_stb_i;
      r1 = m1_cyc_i & m1_stb_i;
      if (owner < 0) begin
        if (r0 && r1) owner = 1 - last;
        else if (r0) owner = 0;
        else if (r1) owner = 1;
      end else begin
        oc = (owner == 0) ? m0_cyc_i : m1_cyc_i;
        if (!oc) begin
          last  = owner;
          owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [130:0] act, exp;
    act = {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
           s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o};
    exp = expect_outs();
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act, exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_set(input logic c, input logic s, input logic w, input logic [0:23] a);
    m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a;
  endtask

  task automatic m1_set(input logic c, input logic s, input logic w, input logic [0:23] a);
    m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a;
  endtask

  initial begin
    int errs, err_at, acks;
    m0_set(0, 0, 0, '0); m0_sel_i = 4'hF; m0_dat_i = 32'hA0A0A0A0;
    m1_set(0, 0, 0, '0); m1_sel_i = 4'h3; m1_dat_i = 32'h5B5B5B5B;
    s_ack_i = 1'b0; s_dat_i = '0;
    reset = 1'b1;
    repeat (2) step();
    chk("reset_scyc", 32'(s_cyc_o), 0);
    chk("reset_outs", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_stb_o} != 0), 0);
    reset = 1'b0;
    step();

    // Simultaneous first requests: m0 wins, m1 next, m0 after that.
    m0_set(1, 1, 1, 24'h000100);
    m1_set(1, 1, 0, 24'h000200);
    #1 chk("both_req_idle", 32'(s_cyc_o), 0);
    step();
    chk("first_grant_m0", 32'(s_adr_o), 32'h000100);
    s_ack_i = 1'b1;
    #1 chk("m0_wr_ack", 32'(m0_ack_o), 1);
    chk("m1_no_ack", 32'(m1_ack_o), 0);
    step();
    s_ack_i = 1'b0;
    m0_set(0, 0, 0, '0);
    step();
    m0_set(1, 1, 1, 24'h000104);
    #1 chk("handover_idle", 32'(s_cyc_o), 0);
    step();
    chk("m1_after_m0", 32'(s_adr_o), 32'h000200);
    s_ack_i = 1'b1; s_dat_i = 32'hCAFEF00D;
    #1 chk("m1_rd_data", m1_dat_o, 32'hCAFEF00D);
    chk("m0_dat_blocked", m0_dat_o, 0);
    step();
    s_ack_i = 1'b0; s_dat_i = '0;
    m1_set(0, 0, 0, '0);
    step();
    step();
    chk("m0_again", 32'(s_adr_o), 32'h000104);
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0;
    m0_set(0, 0, 0, '0);
    step();

    // Lone m0 read, acked two cycles after grant.
    m0_set(1, 1, 0, 24'h000004);
    #1 chk("lat_req_cycle", 32'(s_cyc_o), 0);
    step();
    chk("lat_grant", 32'(s_cyc_o), 1);
    step();
    step();
    s_ack_i = 1'b1; s_dat_i = 32'h12345678;
    #1 chk("m0_rd_data", m0_dat_o, 32'h12345678);
    chk("m0_rd_ack", 32'(m0_ack_o), 1);
    chk("m1_rd_noack", 32'(m1_ack_o), 0);
    step();
    s_ack_i = 1'b0; s_dat_i = '0;
    m0_set(0, 0, 0, '0);
    step();

    // m1 keeps cyc across three strobes while m0 waits.
    m1_set(1, 1, 0, 24'h010000);
    step();
    m0_set(1, 1, 0, 24'h000008);
    for (int i = 0; i < 3; i++) begin
      m1_stb_i = 1'b1;
      s_dat_i = 32'h100 + i;
      step();
      s_ack_i = 1'b1;
      #1 chk("burst_data", m1_dat_o, 32'h100 + i);
      chk("burst_adr", 32'(s_adr_o), 32'h010000);
      chk("burst_m0_wait", 32'(m0_ack_o), 0);
      step();
      s_ack_i = 1'b0;
      m1_stb_i = 1'b0;
      step();
    end
    m1_set(0, 0, 0, '0);
    step();
    chk("burst_idle", 32'(s_cyc_o), 0);
    step();
    chk("m0_after_burst", 32'(s_adr_o), 32'h000008);
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0;
    m0_set(0, 0, 0, '0);
    step();

    // Reset while m0 is stalled with m1 pending.
    m0_set(1, 1, 1, 24'h00000C);
    step();
    m1_set(1, 1, 1, 24'h000300);
    step();
    step();
    reset = 1'b1;
    #1 chk("rst_mid_cyc", 32'({s_cyc_o, s_stb_o}), 0);
    chk("rst_mid_ackerr", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 0);
    m0_set(0, 0, 0, '0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_m1", 32'(s_adr_o), 32'h000300);
    chk("post_rst_cyc", 32'(s_cyc_o), 1);
    s_ack_i = 1'b1;
    step();
    s_ack_i = 1'b0;
    m1_set(0, 0, 0, '0);
    step();

    // Slave never acks.
    m0_set(1, 1, 0, 24'h000010);
    step();
    errs = 0; err_at = -1; acks = 0;
    for (int i = 0; i < 13; i++) begin
      if (m0_err_o) begin errs++; err_at = i; end
      if (m0_ack_o) acks++;
      step();
    end
`ifdef SPMMIO_ARB_TIMEOUT_EN
    chk("to_pulses", 32'(errs), 1);
    chk("to_cycle", 32'(err_at), 8);
`else
    chk("stall_no_err", 32'(errs), 0);
    chk("stall_holds", 32'(s_cyc_o), 1);
`endif
    chk("stall_no_ack", 32'(acks), 0);
    m0_set(0, 0, 0, '0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
